// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller that drives the
// INT / INT_INSTR / ACK handshake into the fetch stage and waits for eoi.
module interrupt_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr_en,
    input  logic [NUM_SRC-1:0] mask_wr_data,
    input  logic               vec_wr_en,
    input  logic [ID_W-1:0]    vec_wr_idx,
    input  logic [31:0]        vec_wr_data,
    input  logic               ACK,
    input  logic               eoi,
    output logic               INT,
    output logic [31:0]        INT_INSTR,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]                state_q, state_d;
    logic                      int_q, int_d;
    logic [31:0]               int_instr_q, int_instr_d;
    logic [ID_W-1:0]           active_id_q, active_id_d;
    logic [NUM_SRC-1:0]        pending_q, pending_d;
    logic [NUM_SRC-1:0]        mask_q, mask_d;
    logic [NUM_SRC-1:0]        irq_q, irq_d;
    logic [NUM_SRC-1:0]        edge_q, edge_d;
    logic [NUM_SRC-1:0][31:0]  vec_q, vec_d;
    logic [NUM_SRC-1:0]        req_vec;
    logic [ID_W-1:0]           winner;

    assign req_vec = pending_q & ~mask_q;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        int_d       = int_q;
        int_instr_d = int_instr_q;
        active_id_d = active_id_q;
        pending_d   = pending_q;
        irq_d       = irq_in;
        // The detected edge is registered once, so pending lands one clock
        // after the edge that first samples the request high.
        edge_d      = irq_in & ~irq_q;
        mask_d      = mask_wr_en ? mask_wr_data : mask_q;
        vec_d       = vec_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec_wr_en && vec_wr_idx == ID_W'(i)) vec_d[i] = vec_wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (|req_vec) begin
                    state_d     = S_REQ;
                    int_d       = 1'b1;
                    active_id_d = winner;
                    int_instr_d = vec_q[winner];
                end
            end
            S_REQ: begin
                if (ACK) begin
                    state_d                = S_SERVICE;
                    int_d                  = 1'b0;
                    pending_d[active_id_q] = 1'b0;
                end
            end
            S_SERVICE: begin
                if (eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new edge beats the acknowledge clear on the same source.
        pending_d = pending_d | edge_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            int_q       <= 1'b0;
            int_instr_q <= '0;
            active_id_q <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
            irq_q       <= '0;
            edge_q      <= '0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            int_instr_q <= int_instr_d;
            active_id_q <= active_id_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
            edge_q      <= edge_d;
            vec_q       <= vec_d;
        end
    end

    assign INT       = int_q;
    assign INT_INSTR = int_instr_q;
    assign active_id = active_id_q;
    assign pending   = pending_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Table-driven bench for interrupt_controller: each row drives one cycle of
// inputs and queues the outputs expected after that clock edge.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        mask_wr_en;
    logic [7:0]  mask_wr_data;
    logic        vec_wr_en;
    logic [2:0]  vec_wr_idx;
    logic [31:0] vec_wr_data;
    logic        ACK;
    logic        eoi;
    logic        INT;
    logic [31:0] INT_INSTR;
    logic [2:0]  active_id;
    logic [7:0]  pending;
    logic        busy;

    interrupt_controller #(.NUM_SRC(8)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .mask_wr_en(mask_wr_en), .mask_wr_data(mask_wr_data),
        .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx), .vec_wr_data(vec_wr_data),
        .ACK(ACK), .eoi(eoi), .INT(INT), .INT_INSTR(INT_INSTR),
        .active_id(active_id), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected output word: {INT, INT_INSTR, active_id, pending, busy}
    typedef struct {
        logic        rst;
        logic [7:0]  irq;
        logic        ack;
        logic        eoi;
        logic        mwr;
        logic [7:0]  md;
        logic        vwr;
        logic [2:0]  vi;
        logic [31:0] vd;
        logic [44:0] exp;
    } vec_t;

    localparam logic [31:0] D0 = 32'hDEAD_0001;

    logic [44:0] sb_q[$];
    vec_t        tbl[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    function automatic vec_t mk(input logic [7:0] irq, input logic ack, input logic ev,
                                input logic mwr, input logic [7:0] md,
                                input logic vwr, input logic [2:0] vi, input logic [31:0] vd,
                                input logic ei, input logic [31:0] einstr, input logic [2:0] eid,
                                input logic [7:0] ep, input logic eb);
        vec_t t;
        t.rst = 1'b0; t.irq = irq; t.ack = ack; t.eoi = ev;
        t.mwr = mwr;  t.md = md;   t.vwr = vwr; t.vi = vi; t.vd = vd;
        t.exp = {ei, einstr, eid, ep, eb};
        return t;
    endfunction

    function automatic vec_t mk_rst();
        vec_t t;
        t = mk(8'h00, 0, 0, 0, 8'h00, 0, 3'd0, 32'h0, 0, 32'h0, 3'd0, 8'h00, 0);
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic step(input vec_t t, input string name);
        logic [44:0] got, expv;
        @(negedge clk);
        rst = t.rst; irq_in = t.irq; ACK = t.ack; eoi = t.eoi;
        mask_wr_en = t.mwr; mask_wr_data = t.md;
        vec_wr_en = t.vwr; vec_wr_idx = t.vi; vec_wr_data = t.vd;
        sb_q.push_back(t.exp);
        @(posedge clk);
        #1;
        got  = {INT, INT_INSTR, active_id, pending, busy};
        expv = sb_q.pop_front();
        n_vec++;
        if (got !== expv) begin
            n_miss++;
            $display("FAIL %s: got INT=%0b INSTR=%h id=%0d pend=%h busy=%0b, expected INT=%0b INSTR=%h id=%0d pend=%h busy=%0b",
                     name, got[44], got[43:12], got[11:9], got[8:1], got[0],
                     expv[44], expv[43:12], expv[11:9], expv[8:1], expv[0]);
        end
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; ACK = 0; eoi = 0;
        mask_wr_en = 0; mask_wr_data = '0; vec_wr_en = 0; vec_wr_idx = '0; vec_wr_data = '0;

        // reset and idle; a pulse on source 3 pends but stays masked
        tbl.push_back(mk_rst());
        tbl.push_back(mk_rst());
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h00,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h00,0));
        tbl.push_back(mk(8'h08,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h00,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h08,0));
        // basic handshake on source 0
        tbl.push_back(mk(8'h00,0,0, 1,8'hFE, 1,3'd0,D0,        0,32'h0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h01,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h0,3'd0,8'h09,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,D0,3'd0,8'h09,1));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,D0,3'd0,8'h09,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h08,1));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h08,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h08,0));
        // priority and masking: sources 1,2,5 together, 2 (and 3) masked
        tbl.push_back(mk(8'h00,0,0, 1,8'h0C, 1,3'd1,32'h11,    0,D0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 1,3'd2,32'h22,    0,D0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 1,3'd5,32'h55,    0,D0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h26,0,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h2E,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h11,3'd1,8'h2E,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h11,3'd1,8'h2C,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h11,3'd1,8'h2C,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h55,3'd5,8'h2C,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h55,3'd5,8'h0C,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h55,3'd5,8'h0C,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h55,3'd5,8'h0C,0));
        tbl.push_back(mk(8'h00,0,0, 1,8'h08, 0,3'd0,32'h0,     0,32'h55,3'd5,8'h0C,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h22,3'd2,8'h0C,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h22,3'd2,8'h08,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h22,3'd2,8'h08,0));
        // stability of an outstanding request for id 3
        tbl.push_back(mk(8'h00,0,0, 1,8'h00, 1,3'd3,32'h33,    0,32'h22,3'd2,8'h08,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 1,3'd3,32'hBEEF,  1,32'h33,3'd3,8'h08,1));
        tbl.push_back(mk(8'h01,0,0, 1,8'h08, 1,3'd3,32'hCAFE,  1,32'h33,3'd3,8'h08,1));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h33,3'd3,8'h09,1));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h33,3'd3,8'h09,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h33,3'd3,8'h01,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h33,3'd3,8'h01,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,D0,3'd0,8'h01,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h00,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h00,0));
        // level source 4: no re-trigger while held, re-arm during SERVICE
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 1,3'd4,32'h44,    0,D0,3'd0,8'h00,0));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h00,0));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,D0,3'd0,8'h10,0));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h10,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h10,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h10,0));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h10,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,0));
        // ACK/eoi in IDLE ignored; edge coinciding with ACK clear keeps pending
        tbl.push_back(mk(8'h00,1,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,0));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h10,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h10,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h10,0));
        tbl.push_back(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0,     1,32'h44,3'd4,8'h10,1));
        tbl.push_back(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,1));
        tbl.push_back(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0,     0,32'h44,3'd4,8'h00,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

        // reset while in REQ, then stray ACK/eoi
        step(mk(8'h01,0,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h44,3'd4,8'h00,0), "rq_pulse");
        step(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h44,3'd4,8'h01,0), "rq_pend");
        step(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0, 1,D0,3'd0,8'h01,1),     "rq_int");
        step(mk_rst(),                                                     "rq_rst");
        step(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "rq_ack_ign");
        step(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "rq_eoi_ign");

        // reset while in SERVICE; vector table cleared back to zero
        step(mk(8'h00,0,0, 1,8'hFE, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "sv_mask");
        step(mk(8'h01,0,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "sv_pulse");
        step(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h01,0),  "sv_pend");
        step(mk(8'h00,0,0, 0,8'h00, 0,3'd0,32'h0, 1,32'h0,3'd0,8'h01,1),  "sv_int");
        step(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,1),  "sv_ack");
        step(mk_rst(),                                                     "sv_rst");
        step(mk(8'h00,0,1, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "sv_eoi_ign");
        step(mk(8'h00,1,0, 0,8'h00, 0,3'd0,32'h0, 0,32'h0,3'd0,8'h00,0),  "sv_ack_ign");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
